// File: rtl/bht_update_ctrl.sv
// Branch-resolution controller: in-order prediction tracking FIFO driving the BHT write port.
// Optional statistics counters are compiled in when BHT_STATS_EN is defined.
module bht_update_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic [ADDR_WIDTH-1:0]      pred_addr,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic                       flush,
    output logic                       wr_enable,
    output logic [ADDR_WIDTH-1:0]      address_wr,
    output logic                       counter_update,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     pending,
    output logic [CNT_WIDTH-1:0]       branch_count,
    output logic [CNT_WIDTH-1:0]       mispredict_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [ADDR_WIDTH:0]   r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_resolve;
    logic                  w_mis;
    logic                  w_clear;
    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic                  w_head_taken;

    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                          (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head_addr  = r_mem[r_rptr[AW-1:0]][ADDR_WIDTH:1];
    assign w_head_taken = r_mem[r_rptr[AW-1:0]][0];
    assign w_resolve    = res_valid && !w_empty;
    assign w_mis        = w_resolve && (res_taken != w_head_taken);
    // A clear (flush or mispredict) wins over both pop and push this cycle.
    assign w_clear      = flush || w_mis;
    assign w_push       = pred_valid && !w_full && !w_clear;

    assign pred_ready   = !w_full;
    assign pending      = r_wptr - r_rptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {pred_addr, pred_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_clear) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_resolve) r_rptr <= r_rptr + PW'(1);
            if (w_push)    r_wptr <= r_wptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_enable      <= 1'b0;
            address_wr     <= '0;
            counter_update <= 1'b0;
            mispredict     <= 1'b0;
        end else begin
            wr_enable  <= w_resolve;
            mispredict <= w_mis;
            if (w_resolve) begin
                address_wr     <= w_head_addr;
                counter_update <= res_taken;
            end
        end
    end

`ifdef BHT_STATS_EN
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mis_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_mis_cnt    <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            if (w_mis && (r_mis_cnt != '1))        r_mis_cnt    <= r_mis_cnt + CNT_WIDTH'(1);
        end
    end

    assign branch_count     = r_branch_cnt;
    assign mispredict_count = r_mis_cnt;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule
